// File: rtl/online_otfc_conv.sv
// online_otfc_conv: MSD-first on-the-fly conversion of one borrow-save word
// (ND signed digits, digit i = {p,n} with value p-n and weight 2^i) into an
// ND+1 bit two's complement result, one digit per clock.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a producer holding valid keeps
// its data stable until the transfer.
//
// FSM state is visible as the internal signal state_dbg for bound checkers.
//
// Optional feature macro: OTFC_ERR_EN adds the dig_err output, which flags
// any consumed digit carrying the illegal code 2'b11.
`timescale 1ns/1ps

module online_otfc_conv #(
    parameter  int Stage = 4,
    localparam int ND    = Stage + 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*ND-1:0]   x_rd,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef OTFC_ERR_EN
    output logic              dig_err,
`endif
    output logic [ND:0]       y_tc
);

    localparam int CW = $clog2(ND);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    state_t          state_dbg;
    logic [2*ND-1:0] sr_q;
    logic [ND:0]     q_q;
    logic [ND:0]     qm_q;
    logic [ND:0]     q_n;
    logic [ND:0]     qm_n;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      dig;
    logic            accept;
    logic            last_dig;

    assign state_dbg = state_q;

    // The shift register presents the most significant unconsumed digit at its top.
    assign dig      = sr_q[2*ND-1 -: 2];
    assign last_dig = (cnt_q == '0);

    // OTFC append step: Q holds the converted prefix, QM holds prefix minus one ulp.
    always_comb begin
        q_n  = q_q;
        qm_n = qm_q;
        case (dig)
            2'b10: begin
                q_n  = {q_q[ND-1:0], 1'b1};
                qm_n = {q_q[ND-1:0], 1'b0};
            end
            2'b01: begin
                q_n  = {qm_q[ND-1:0], 1'b1};
                qm_n = {qm_q[ND-1:0], 1'b0};
            end
            default: begin
                // 2'b00 and the illegal 2'b11 both carry value zero
                q_n  = {q_q[ND-1:0], 1'b0};
                qm_n = {qm_q[ND-1:0], 1'b1};
            end
        endcase
    end

    // Next-state and handshake outputs; in DONE a new word may enter alongside the output transfer.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (last_dig) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
                if (out_ready) begin
                    state_d = in_valid ? CONV : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion datapath: load on accept, then shift one digit per CONV cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            q_q   <= '0;
            qm_q  <= '1;
            cnt_q <= '0;
            y_tc  <= '0;
        end else if (accept) begin
            sr_q  <= x_rd;
            q_q   <= '0;
            qm_q  <= '1;
            cnt_q <= CW'(ND - 1);
        end else if (state_q == CONV) begin
            sr_q <= {sr_q[2*ND-3:0], 2'b00};
            q_q  <= q_n;
            qm_q <= qm_n;
            if (last_dig) begin
                y_tc <= q_n;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

`ifdef OTFC_ERR_EN
    // Sticky illegal-digit flag for the word in flight; cleared when a new word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_err <= 1'b0;
        end else if (accept) begin
            dig_err <= 1'b0;
        end else if (state_q == CONV && dig == 2'b11) begin
            dig_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_online_otfc_conv.sv
// Testbench for online_otfc_conv (Stage=4, ND=9, 10-bit result).
`timescale 1ns/1ps

module tb_online_otfc_conv;

    localparam int STAGE = 4;
    localparam int ND    = STAGE + 5;
    localparam int XW    = 2 * ND;
    localparam int W     = ND + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x_rd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y_tc;
`ifdef OTFC_ERR_EN
    logic          dig_err;
`endif

    int checks;
    int errors;
    int sent;
    int got;

    logic [W-1:0] exp_q[$];

    online_otfc_conv #(.Stage(STAGE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_rd      (x_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef OTFC_ERR_EN
        .dig_err   (dig_err),
`endif
        .y_tc      (y_tc)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [XW-1:0] x);
        int acc;
        acc = 0;
        for (int i = 0; i < ND; i++) begin
            acc += (int'(x[2*i+1]) - int'(x[2*i])) * (1 << i);
        end
        return W'(acc);
    endfunction

    // ---------------- scoreboard ----------------
    // Handshakes are judged at the falling edge, where inputs and outputs are settled
    // for the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got y_tc=%h with empty expected queue", y_tc);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    got++;
                    if (y_tc !== e) begin
                        errors++;
                        $display("FAIL sb_y_tc: got %h expected %h (result #%0d)", y_tc, e, got);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(x_rd));
                sent++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a word and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [XW-1:0] x);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        x_rd     = x;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b expected 1 within 400 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_rd     = XW'($urandom);
    endtask

    // Count rising edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int n);
        bit ok;
        ok = 0;
        n  = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL out_timeout: out_valid=%b expected 1 within 100 cycles", out_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || y_tc !== '0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b y_tc=%h expected 0 and 000", out_valid, y_tc);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [XW-1:0] xs [6];
        logic [W-1:0]  ys [6];
        int n;
        xs = '{18'h00000, 18'h00002, 18'h10000, 18'h20001, 18'h2AAAA, 18'h15555};
        ys = '{10'h000,   10'h001,   10'h300,   10'h0FF,   10'h1FF,   10'h201};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send(xs[k]);
            wait_out(n);
            checks++;
            if (n != ND) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles expected %0d", k, n, ND);
            end
            checks++;
            if (y_tc !== ys[k]) begin
                errors++;
                $display("FAIL vector_%0d: x_rd=%h got %h expected %h", k, xs[k], y_tc, ys[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send(18'h20001);
        wait_out(n);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || y_tc !== 10'h0FF || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: out_valid=%b y_tc=%h in_ready=%b expected 1 0ff 0",
                         c, out_valid, y_tc, in_ready);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        x_rd      = 18'h2AAAA;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_in_ready: got %b expected 1 with out_ready=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_rd     = 18'h15555;
        wait_out(n);
        checks++;
        if (n != ND || y_tc !== 10'h1FF) begin
            errors++;
            $display("FAIL overlap_accept: latency=%0d y_tc=%h expected %0d 1ff", n, y_tc, ND);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        int n;
        out_ready = 1'b1;
        send(18'h15555);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y_tc !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b y_tc=%h in_ready=%b expected 0 000 0",
                     out_valid, y_tc, in_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(18'h2AAAA);
        wait_out(n);
        checks++;
        if (n != ND || y_tc !== 10'h1FF) begin
            errors++;
            $display("FAIL after_reset: latency=%0d y_tc=%h expected %0d 1ff", n, y_tc, ND);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef OTFC_ERR_EN
    task automatic test_dig_err();
        int n;
        out_ready = 1'b1;
        send(18'h000C0);
        wait_out(n);
        checks++;
        if (y_tc !== 10'h000 || dig_err !== 1'b1) begin
            errors++;
            $display("FAIL dig_err_set: y_tc=%h dig_err=%b expected 000 1", y_tc, dig_err);
        end
        @(posedge clk);
        #1;
        send(18'h00002);
        wait_out(n);
        checks++;
        if (y_tc !== 10'h001 || dig_err !== 1'b0) begin
            errors++;
            $display("FAIL dig_err_clear: y_tc=%h dig_err=%b expected 001 0", y_tc, dig_err);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_random();
        bit stop;
        int s0;
        stop = 0;
        s0 = sent;
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(XW'($urandom));
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || sent - s0 != 1000) begin
            errors++;
            $display("FAIL random_drain: pending=%0d sent=%0d expected 0 and 1000",
                     exp_q.size(), sent - s0);
        end
        checks++;
        if (got != sent) begin
            errors++;
            $display("FAIL random_count: received %0d results expected %0d", got, sent);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        sent   = 0;
        got    = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_mid_reset();
`ifdef OTFC_ERR_EN
        test_dig_err();
`endif
        // results discarded by the mid-conversion reset never reach the output
        got  = 0;
        sent = 0;
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
